// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word width, arbiter state encoding and the
// default fetch starvation limit.
package cpu_pkg;

  localparam int unsigned WORD_W            = 16;
  localparam int unsigned STARVE_W          = 3;
  localparam int unsigned DEF_STARVE_LIMIT  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port variable-latency
// memory; data has priority, bounded by a fetch starvation counter.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                r_mem_en,    w_mem_en_nxt;
  logic                r_mem_wr,    w_mem_wr_nxt;
  logic [WORD_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [WORD_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_if_ready,  w_if_ready_nxt;
  logic                r_d_ready,   w_d_ready_nxt;
  logic [WORD_W-1:0]   r_if_rdata,  w_if_rdata_nxt;
  logic [WORD_W-1:0]   r_d_rdata,   w_d_rdata_nxt;
  logic                w_turnaround;
  logic                w_starved;
  logic                w_pick_if;

  // A completion cycle grants nothing, so held requesters re-arbitrate together from k+2.
  assign w_turnaround = r_if_ready | r_d_ready;
  assign w_starved    = (r_starve == STARVE_W'(STARVE_LIMIT));
  assign w_pick_if    = if_req & (~d_req | w_starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_starve    <= w_starve_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve;
    w_mem_en_nxt    = r_mem_en;
    w_mem_wr_nxt    = r_mem_wr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ready_nxt  = 1'b0;
    w_d_ready_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    case (r_state)
      IDLE: begin
        if (!w_turnaround && (if_req || d_req)) begin
          w_mem_en_nxt = 1'b1;
          if (w_pick_if) begin
            w_state_nxt    = IF_BUSY;
            w_mem_wr_nxt   = 1'b0;
            w_mem_addr_nxt = if_addr;
            w_starve_nxt   = '0;
          end else begin
            w_state_nxt     = D_BUSY;
            w_mem_wr_nxt    = d_wr;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
            if (if_req && !w_starved) begin
              w_starve_nxt = r_starve + STARVE_W'(1);
            end
          end
        end
      end
      IF_BUSY: begin
        if (mem_valid) begin
          w_state_nxt    = IDLE;
          w_mem_en_nxt   = 1'b0;
          w_mem_wr_nxt   = 1'b0;
          w_if_ready_nxt = 1'b1;
          w_if_rdata_nxt = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_valid) begin
          w_state_nxt   = IDLE;
          w_mem_en_nxt  = 1'b0;
          w_mem_wr_nxt  = 1'b0;
          w_d_ready_nxt = 1'b1;
          if (!r_mem_wr) begin
            w_d_rdata_nxt = mem_rdata;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_mem_en_nxt = 1'b0;
        w_mem_wr_nxt = 1'b0;
      end
    endcase
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_stall  = if_req & ~r_if_ready;
  assign d_stall   = d_req & ~r_d_ready;

endmodule
